// File: rtl/tdc_meas_seq_pkg.sv
// tdc_pkg: shared state encoding and sizing helpers for the TDC measurement sequencer
package tdc_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, GAP, CAPTURE, SETTLE, SAMPLE, DONE} tdc_seq_state_t;
  localparam int SETTLE_EXTRA = 2;
  function automatic int hw_width(input int n);
    return $clog2(n) + 1;
  endfunction
  function automatic int settle_cyc(input int n_sync);
    return n_sync + SETTLE_EXTRA;
  endfunction
endpackage

// File: rtl/tdc_meas_seq_if.sv
// tdc_meas_seq_if: stimulus and readback pins between the sequencer and the TDC core
interface tdc_meas_seq_if #(parameter int HW_W = 7) ();
  logic clk_launch, clk_capture, pg_src, pg_bypass, pg_tog, pg_in;
  logic [HW_W-1:0] hw_in;
  modport master(output clk_launch, clk_capture, pg_src, pg_bypass, pg_tog, pg_in, input hw_in);
  modport slave(input clk_launch, clk_capture, pg_src, pg_bypass, pg_tog, pg_in, output hw_in);
endinterface

// File: rtl/tdc_hw_accum.sv
// tdc_hw_accum: per-burst sum/min/max of clamped Hamming weights with sticky overrange
module tdc_hw_accum #(
  parameter int N = 64,
  parameter int HW_W = 7,
  parameter int SW = 23
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic empty,
  input  logic en,
  input  logic [HW_W-1:0] hw_in,
  output logic [SW-1:0] sum_hw,
  output logic [HW_W-1:0] min_hw,
  output logic [HW_W-1:0] max_hw,
  output logic overrange
);
  logic over;
  logic [HW_W-1:0] v;
  assign over = hw_in > HW_W'(N);
  assign v = over ? HW_W'(N) : hw_in;
  // clear on accepted start (empty bursts report zero extrema), accumulate on SAMPLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_hw <= '0;
      min_hw <= '1;
      max_hw <= '0;
      overrange <= 1'b0;
    end else if (clr) begin
      sum_hw <= '0;
      min_hw <= empty ? '0 : '1;
      max_hw <= '0;
      overrange <= 1'b0;
    end else if (en) begin
      sum_hw <= sum_hw + SW'(v);
      min_hw <= v < min_hw ? v : min_hw;
      max_hw <= v > max_hw ? v : max_hw;
      overrange <= overrange | over;
    end
  end
endmodule

// File: rtl/tdc_meas_seq.sv
// tdc_meas_seq: burst sequencer driving TDC launch/capture strobes and accumulating its readback
module tdc_meas_seq import tdc_pkg::*; #(
  parameter int N = 64,
  parameter int N_SYNC = 1,
  parameter int CNT_W = 16,
  parameter int GAP_W = 4,
  localparam int HW_W = hw_width(N)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic [CNT_W-1:0] n_samples,
  input  logic [GAP_W-1:0] gap,
  input  logic cfg_src,
  input  logic cfg_bypass,
  input  logic cfg_tog,
  input  logic cfg_pol,
  input  logic cfg_alt,
  tdc_meas_seq_if.master t,
  output logic busy,
  output logic done,
  output logic [HW_W+CNT_W-1:0] sum_hw,
  output logic [HW_W-1:0] min_hw,
  output logic [HW_W-1:0] max_hw,
  output logic overrange
);
  localparam int SC = settle_cyc(N_SYNC);
  localparam int TW = GAP_W > $clog2(SC + 1) ? GAP_W : $clog2(SC + 1);
  tdc_seq_state_t state;
  logic [TW-1:0] tmr;
  logic [CNT_W-1:0] rem;
  logic [GAP_W-1:0] gap_r;
  logic alt_r, acc_clr, acc_en;
  assign acc_clr = state == IDLE && start;
  assign acc_en = state == SAMPLE && !abort;
  // sequencer FSM; strobes and done are asserted on the edge entering their state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr <= '0;
      rem <= '0;
      gap_r <= '0;
      alt_r <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      t.clk_launch <= 1'b0;
      t.clk_capture <= 1'b0;
      t.pg_src <= 1'b0;
      t.pg_bypass <= 1'b0;
      t.pg_tog <= 1'b0;
      t.pg_in <= 1'b0;
    end else begin
      t.clk_launch <= 1'b0;
      t.clk_capture <= 1'b0;
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            gap_r <= gap;
            rem <= n_samples;
            alt_r <= cfg_alt;
            t.pg_src <= cfg_src;
            t.pg_bypass <= cfg_bypass;
            t.pg_tog <= cfg_tog;
            t.pg_in <= cfg_pol;
            busy <= 1'b1;
            if (n_samples == '0) begin
              state <= DONE;
              done <= 1'b1;
            end else begin
              state <= LAUNCH;
              t.clk_launch <= 1'b1;
            end
          end
          LAUNCH: if (gap_r == '0) begin
            state <= CAPTURE;
            t.clk_capture <= 1'b1;
          end else begin
            state <= GAP;
            tmr <= TW'(gap_r) - TW'(1);
          end
          GAP: if (tmr == '0) begin
            state <= CAPTURE;
            t.clk_capture <= 1'b1;
          end else tmr <= tmr - TW'(1);
          CAPTURE: begin
            state <= SETTLE;
            tmr <= TW'(SC - 1);
          end
          SETTLE: if (tmr == '0) state <= SAMPLE; else tmr <= tmr - TW'(1);
          SAMPLE: begin
            rem <= rem - CNT_W'(1);
            if (alt_r) t.pg_in <= ~t.pg_in;
            if (rem == CNT_W'(1)) begin
              state <= DONE;
              done <= 1'b1;
            end else begin
              state <= LAUNCH;
              t.clk_launch <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
  tdc_hw_accum #(.N(N), .HW_W(HW_W), .SW(HW_W + CNT_W)) u_acc (
    .clk(clk),
    .rst_n(rst_n),
    .clr(acc_clr),
    .empty(n_samples == '0),
    .en(acc_en),
    .hw_in(t.hw_in),
    .sum_hw(sum_hw),
    .min_hw(min_hw),
    .max_hw(max_hw),
    .overrange(overrange)
  );
endmodule

// File: tb/tb_tdc_meas_seq.sv
// tb_tdc_meas_seq: table-driven bursts with a result scoreboard plus abort/reset/busy-start sequences
module tb_tdc_meas_seq;
  localparam int N = 64, NS = 1, CW = 16, GW = 4, HW = 7;
  typedef struct {
    int n;
    int gap;
    logic [3:0][HW-1:0] v;
    bit src, byp, tog, pol, alt, restart;
    int sum, mn, mx;
    bit ov;
  } vec_t;
  typedef struct {int sum, mn, mx, dc; bit ov;} exp_t;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [CW-1:0] n_samples = '0;
  logic [GW-1:0] gap = '0;
  logic cfg_src = 0, cfg_bypass = 0, cfg_tog = 0, cfg_pol = 0, cfg_alt = 0;
  logic busy, done, overrange;
  logic [HW+CW-1:0] sum_hw;
  logic [HW-1:0] min_hw, max_hw;
  int checks = 0, errors = 0;
  exp_t q[$];
  vec_t vecs[7];
  tdc_meas_seq_if #(.HW_W(HW)) t();
  tdc_meas_seq #(.N(N), .N_SYNC(NS), .CNT_W(CW), .GAP_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .n_samples(n_samples), .gap(gap),
    .cfg_src(cfg_src), .cfg_bypass(cfg_bypass), .cfg_tog(cfg_tog), .cfg_pol(cfg_pol), .cfg_alt(cfg_alt),
    .t(t), .busy(busy), .done(done), .sum_hw(sum_hw), .min_hw(min_hw), .max_hw(max_hw),
    .overrange(overrange)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input longint a, input longint b);
    checks++;
    if (a != b) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, b);
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sum"}, sum_hw, 0);
    chk({tag, "_min"}, min_hw, 127);
    chk({tag, "_max"}, max_hw, 0);
    chk({tag, "_ov"}, overrange, 0);
    chk({tag, "_launch"}, t.clk_launch, 0);
    chk({tag, "_capture"}, t.clk_capture, 0);
    chk({tag, "_pg"}, {t.pg_src, t.pg_bypass, t.pg_tog, t.pg_in}, 0);
  endtask
  task automatic run(input vec_t v);
    exp_t e, g;
    int k, ll, launches;
    bit got;
    n_samples = CW'(v.n);
    gap = GW'(v.gap);
    cfg_src = v.src;
    cfg_bypass = v.byp;
    cfg_tog = v.tog;
    cfg_pol = v.pol;
    cfg_alt = v.alt;
    start = 1;
    e = '{v.sum, v.mn, v.mx, v.n * (v.gap + NS + 5) + 1, v.ov};
    q.push_back(e);
    k = 0;
    ll = -100;
    launches = 0;
    got = 0;
    for (int c = 1; c <= 400 && !got; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start = 0;
      if (v.restart && c == 4) begin
        start = 1;
        n_samples = 1;
        gap = 7;
        cfg_src = ~v.src;
      end
      if (v.restart && c == 5) start = 0;
      if (t.clk_launch) begin
        launches++;
        ll = c;
      end
      if (t.clk_capture) begin
        chk("cap_gap", c - ll, v.gap + 1);
        chk("pg_in_step", t.pg_in, v.pol ^ (v.alt & k[0]));
        t.hw_in = v.v[k % 4];
        k++;
      end
      if (done) begin
        got = 1;
        if (q.size() == 0) chk("unexpected_done", done, 0);
        else begin
          g = q.pop_front();
          chk("done_cyc", c, g.dc);
          chk("sum", sum_hw, g.sum);
          chk("min", min_hw, g.mn);
          chk("max", max_hw, g.mx);
          chk("overrange", overrange, g.ov);
        end
      end
    end
    chk("done_seen", got, 1);
    q.delete();
    chk("launches", launches, v.n);
    chk("pg_src", t.pg_src, v.src);
    chk("pg_bypass", t.pg_bypass, v.byp);
    chk("pg_tog", t.pg_tog, v.tog);
    chk("pg_in_final", t.pg_in, v.pol ^ (v.alt & v.n[0]));
    @(posedge clk);
    #1;
    chk("busy_after", busy, 0);
    chk("done_once", done, 0);
    t.hw_in = '0;
  endtask
  initial begin
    int dn;
    t.hw_in = '0;
    vecs[0] = '{4, 2, {7'd40, 7'd30, 7'd20, 7'd10}, 0, 0, 0, 0, 0, 0, 100, 10, 40, 0};
    vecs[1] = '{3, 0, {7'd0, 7'd13, 7'd10, 7'd7}, 1, 0, 1, 1, 0, 0, 30, 7, 13, 0};
    vecs[2] = '{0, 5, {7'd50, 7'd50, 7'd50, 7'd50}, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[3] = '{3, 1, {7'd70, 7'd70, 7'd70, 7'd70}, 0, 0, 0, 0, 0, 0, 192, 64, 64, 1};
    vecs[4] = '{3, 3, {7'd0, 7'd65, 7'd0, 7'd64}, 0, 0, 0, 0, 1, 0, 128, 0, 64, 1};
    vecs[5] = '{5, 15, {7'd4, 7'd3, 7'd2, 7'd1}, 1, 1, 1, 1, 1, 0, 11, 1, 4, 0};
    vecs[6] = '{2, 0, {7'd0, 7'd0, 7'd3, 7'd9}, 0, 0, 0, 0, 0, 1, 12, 3, 9, 0};
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) run(vecs[i]);
    n_samples = 2;
    gap = 0;
    cfg_pol = 1;
    cfg_src = 1;
    cfg_alt = 0;
    t.hw_in = 25;
    start = 1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start = 0;
    end
    chk("pre_rst_sum", sum_hw, 25);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_pg_in", t.pg_in, 1);
    rst_n = 0;
    #1;
    check_reset_outputs("mid_rst");
    #1;
    rst_n = 1;
    dn = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      dn += int'(done);
    end
    chk("rst_no_done", dn, 0);
    t.hw_in = 33;
    n_samples = 4;
    gap = 5;
    start = 1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start = 0;
    end
    chk("pre_abort_busy", busy, 1);
    abort = 1;
    @(posedge clk);
    #1;
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_launch", t.clk_launch, 0);
    chk("abort_capture", t.clk_capture, 0);
    dn = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      dn += int'(done) + int'(t.clk_capture) + int'(busy);
    end
    chk("abort_quiet", dn, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tdc_meas_seq.md
# tdc_meas_seq

Single-clock measurement sequencer that drives the TDC core's stimulus pins (launch/capture strobes, pulse-generator controls) and reads back its Hamming-weight result. One `start` triggers a burst of `n_samples` launch→capture→sample cycles with a programmable launch-to-capture gap. Per-burst sum, min and max of the returned Hamming weight are accumulated. The block is the initiator/reader for the TDC top, which is otherwise driven from pads.

## Interface
Parameters:
- `N`, 64: TDC delay-line taps. `HW_W = $clog2(N)+1` (7).
- `N_SYNC`, 1: synchronizer depth inside the TDC core. Sets settle time.
- `CNT_W`, 16: sample-count width.
- `GAP_W`, 4: launch-to-capture gap width.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin burst; sampled only in IDLE.
- `abort`  in  1  terminate burst; no `done`.
- `n_samples`  in  CNT_W  samples per burst; latched at start.
- `gap`  in  GAP_W  clk cycles between launch and capture; latched at start.
- `cfg_src`, `cfg_bypass`, `cfg_tog`  in  1 each  pulse-generator config; latched at start.
- `cfg_pol`  in  1  initial `pg_in` level.
- `cfg_alt`  in  1  invert `pg_in` after every sample.
- `clk_launch`, `clk_capture`  out  1  registered one-cycle strobes to the TDC.
- `pg_src`, `pg_bypass`, `pg_tog`, `pg_in`  out  1  registered TDC controls.
- `hw_in`  in  HW_W  Hamming weight from the TDC.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse; results valid from this cycle.
- `sum_hw`  out  HW_W+CNT_W  sum of samples.
- `min_hw`, `max_hw`  out  HW_W  extrema.
- `overrange`  out  1  sticky per burst: some `hw_in` > N.

## Operation
- States: IDLE, LAUNCH, GAP, CAPTURE, SETTLE, SAMPLE, DONE.
- IDLE: if `start` is high, latch config and clear the accumulators. Go to DONE if `n_samples == 0`, otherwise go to LAUNCH.
- Clearing the accumulators sets sum = 0, min = all-ones, max = 0, `overrange` = 0.
- LAUNCH: `clk_launch` = 1. Next state is GAP, or CAPTURE if `gap == 0`.
- GAP: lasts `gap` cycles, then CAPTURE.
- CAPTURE: `clk_capture` = 1, then SETTLE.
- SETTLE: lasts `N_SYNC + 2` cycles, then SAMPLE.
- SAMPLE: register `hw_in` into sum/min/max.
  - If `hw_in > N`: set `overrange` and clamp the value to N before accumulating.
  - Decrement the remaining count.
  - If `cfg_alt`: toggle `pg_in`.
  - Next state is LAUNCH while samples remain, otherwise DONE.
- DONE: `done` = 1 for one cycle, then IDLE.
- Results hold until the next accepted `start`.
- If `n_samples == 0`: `done` fires, sum = 0, and min and max are forced to 0.
- `start` while busy is ignored.
- `abort` in any non-IDLE state returns to IDLE on the next edge. `done` is not pulsed and strobes deassert. `abort` has priority over every other transition.
- The sum cannot overflow, since it is sized HW_W+CNT_W.

## Timing
- `start` is sampled at cycle 0. First LAUNCH is at cycle 1.
- Per-sample period `P = gap + N_SYNC + 5`.
- Sample k (1-based) is registered at cycle k·P. `done` is at cycle n·P+1.
- `clk_launch` to `clk_capture` rising edges are `gap+1` clk cycles apart.
- Config outputs change only at an accepted `start`. `pg_in` changes only at start and SAMPLE.
- Reset values: all outputs 0 except `min_hw` = all-ones. State is IDLE.
- Reset mid-burst is asynchronous and returns the block to IDLE immediately, with all outputs at reset values.

## Structure
- Package `tdc_pkg`:
  - state enum `tdc_seq_state_t`
  - function `hw_width(N)`
  - localparam `SETTLE_CYC(N_SYNC) = N_SYNC + 2`
- Sub-module `tdc_hw_accum`: sum/min/max/overrange with clear and accumulate-enable inputs. This module owns the clamping rule.
- FSM and counters live in the top sequencer.

## Test plan
- n_samples=4, gap=2, N_SYNC=1, hw_in=10,20,30,40 at the SAMPLE cycles → `done` at cycle 33, sum=100, min=10, max=40, overrange=0.
- gap=0 → `clk_capture` high exactly one cycle after `clk_launch`. P=6.
- n_samples=0 → `done` at cycle 1, sum/min/max = 0, no strobes.
- n_samples=3, hw_in=70 with N=64 → sum=192, max=64, overrange=1.
- cfg_alt=1, cfg_pol=0, n_samples=3 → `pg_in` 0→1→0→1 at successive SAMPLEs.
- Cover both kill paths:
  - `abort` during GAP → IDLE next cycle, no `done`, `busy`=0.
  - `rst_n` low mid-SETTLE → all outputs at reset values immediately.
  - `start` while busy → ignored.
